mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 143 ++++++++++++++
 tb/tb_mac_accumulator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Pipelined unsigned multiply-accumulate, L products per result block.
// Define MAC_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module multiplier_N_bits #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  logic [2*N-1:0] w_a_ext;

  assign w_a_ext = {{N{1'b0}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p + (w_a_ext << i);
    end
  end
endmodule

module mac_accumulator #(
  parameter int N = 4,
  parameter int L = 4,
  parameter int G = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N+G-1:0]  acc_out,
  output logic              ovf
);
  localparam int ACC_W = 2*N+G;
  localparam int SW    = ACC_W+1;
  localparam int CW    = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_v1;
  logic             r_v2;
  logic [2*N-1:0]   w_prod;
  logic [2*N-1:0]   r_prod;
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [SW-1:0]    w_sum;
  logic             w_accept;
  logic             w_last;
  logic             w_handoff;

  multiplier_N_bits #(.N(N)) u_mul (
    .a (r_a),
    .b (r_b),
    .p (w_prod)
  );

  assign in_ready  = rst_n && !clear && (r_state == S_RUN);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(L-1));
  assign w_handoff = (r_state == S_HOLD) && out_ready;
  assign w_sum     = {1'b0, r_acc} + SW'(r_prod);

  assign out_valid = (r_state == S_HOLD);
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;

  // DRAIN ends on the edge that folds the final product
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_v1) w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    if (r_v2) begin
      w_ovf_nxt = r_ovf | w_sum[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
      w_acc_nxt = w_ovf_nxt ? '1 : w_sum[ACC_W-1:0];
`else
      w_acc_nxt = w_sum[ACC_W-1:0];
`endif
    end
    if (w_handoff) begin
      w_acc_nxt = '0;
      w_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_a     <= '0;
      r_b     <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= S_RUN;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_v1    <= w_accept;
      r_v2    <= r_v1;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_cnt <= w_last ? '0 : CW'(r_cnt + 1'b1);
      end
      if (r_v1) r_prod <= w_prod;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized and directed bench for mac_accumulator with a queue-based model.
// Honours MAC_ACC_SATURATE_EN for the overflow expectations.
module tb_mac_accumulator;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int G  = 2;
  localparam int W  = 2*N+G;
  localparam int W2 = 2*N;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         clear = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [N-1:0] a = 0;
  logic [N-1:0] b = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] acc_out;
  logic         ovf;

  logic          d2_clear = 0;
  logic          d2_in_valid = 0;
  logic          d2_in_ready;
  logic [N-1:0]  d2_a = 0;
  logic [N-1:0]  d2_b = 0;
  logic          d2_out_valid;
  logic          d2_out_ready = 0;
  logic [W2-1:0] d2_acc_out;
  logic          d2_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.N(N), .L(L), .G(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf)
  );

  mac_accumulator #(.N(N), .L(2), .G(0)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (d2_clear),
    .in_valid  (d2_in_valid),
    .in_ready  (d2_in_ready),
    .a         (d2_a),
    .b         (d2_b),
    .out_valid (d2_out_valid),
    .out_ready (d2_out_ready),
    .acc_out   (d2_acc_out),
    .ovf       (d2_ovf)
  );

  task automatic chk(string nm, longint got, longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: block bookkeeping plus a queue of products due at a cycle
  typedef struct {
    longint p;
    int     due;
  } pend_t;

  pend_t  pq[$];
  longint m_acc;
  bit     m_ovf;
  bit     m_hold;
  int     m_taken;
  int     cyc;
  longint maxv = (longint'(1) << W) - 1;

  task automatic model_reset();
    pq.delete();
    m_acc = 0;
    m_ovf = 0;
    m_hold = 0;
    m_taken = 0;
  endtask

  task automatic fold(longint p);
    m_acc = m_acc + p;
    if (m_acc > maxv) begin
      m_ovf = 1;
      m_acc = m_acc & maxv;
    end
`ifdef MAC_ACC_SATURATE_EN
    if (m_ovf) m_acc = maxv;
`endif
  endtask

  function automatic bit model_ready();
    return !m_hold && (m_taken < L) && !clear;
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = model_ready();
    cyc++;
    if (clear) begin
      model_reset();
      return;
    end
    while (pq.size() > 0 && pq[0].due == cyc) begin
      fold(pq[0].p);
      void'(pq.pop_front());
    end
    if (m_hold && out_ready) begin
      m_acc = 0;
      m_ovf = 0;
      m_hold = 0;
      m_taken = 0;
    end
    if (in_valid && rdy) begin
      pq.push_back('{longint'(a) * longint'(b), cyc + 2});
      m_taken++;
    end
    if (!m_hold && m_taken == L && pq.size() == 0) m_hold = 1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cmp_in_ready", in_ready, model_ready());
        chk("cmp_out_valid", out_valid, m_hold);
        chk("cmp_acc_out", acc_out, m_acc);
        chk("cmp_ovf", ovf, m_ovf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [N-1:0] x, logic [N-1:0] y);
    in_valid = 1;
    a = x;
    b = y;
    step();
    in_valid = 0;
  endtask

  task automatic handoff();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    d2_in_valid = 1;
    d2_a = 15;
    d2_b = 15;
    step();
    step();
    d2_in_valid = 0;
    step();
    step();
    chk("g0_out_valid", d2_out_valid, 1);
    chk("g0_ovf", d2_ovf, 1);
`ifdef MAC_ACC_SATURATE_EN
    chk("g0_acc_sat", d2_acc_out, 255);
`else
    chk("g0_acc_wrap", d2_acc_out, 194);
`endif
    chk("g0_in_ready", d2_in_ready, 0);

    send(3, 5);
    send(2, 7);
    send(15, 15);
    send(1, 1);
    chk("blk_drain_in_ready", in_ready, 0);
    step();
    chk("blk_valid_early", out_valid, 0);
    step();
    chk("blk_valid", out_valid, 1);
    chk("blk_acc", acc_out, 255);
    chk("blk_ovf", ovf, 0);
    chk("model_blk_acc", m_acc, 255);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", acc_out, 255);
      chk("hold_in_ready", in_ready, 0);
    end
    handoff();
    chk("hand_in_ready", in_ready, 1);
    chk("hand_acc", acc_out, 0);
    chk("hand_valid", out_valid, 0);

    send(3, 5);
    send(2, 7);
    step();
    step();
    chk("partial_acc", acc_out, 29);
    chk("model_partial", m_acc, 29);
    clear = 1;
    #1 chk("clear_in_ready", in_ready, 0);
    step();
    clear = 0;
    chk("clear_acc", acc_out, 0);
    for (int i = 0; i < 4; i++) send(1, 1);
    step();
    step();
    chk("after_clear_valid", out_valid, 1);
    chk("after_clear_acc", acc_out, 4);
    handoff();

    for (int i = 0; i < 4; i++) send(2, 3);
    step();
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_acc", acc_out, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) send(2, 3);
    step();
    step();
    chk("fresh_valid", out_valid, 1);
    chk("fresh_acc", acc_out, 24);
    handoff();

    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      a = in_valid ? 4'd4 : N'($urandom);
      b = in_valid ? 4'd4 : N'($urandom);
      step();
    end
    in_valid = 0;
    step();
    chk("toggle_valid", out_valid, 1);
    chk("toggle_acc", acc_out, 64);
    handoff();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      a         = N'($urandom);
      b         = N'($urandom);
      out_ready = ($urandom % 3) == 0;
      clear     = ($urandom % 50) == 0;
      step();
    end
    in_valid = 0;
    out_ready = 0;
    clear = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
